// File: rtl/interrupt_ctrl_if.sv
// Bus bundle between the CPU store/read ports and interrupt_ctrl.
// master: CPU side (drives writes and rd_addr); slave: controller side.
interface interrupt_ctrl_if;
  logic [3:0]  mem_we;
  logic [17:0] mem_write_addr;
  logic [31:0] mem_write_data;
  logic [17:0] rd_addr;
  logic [31:0] rd_data;
  logic        rd_hit;

  modport master (
    output mem_we,
    output mem_write_addr,
    output mem_write_data,
    output rd_addr,
    input  rd_data,
    input  rd_hit
  );

  modport slave (
    input  mem_we,
    input  mem_write_addr,
    input  mem_write_data,
    input  rd_addr,
    output rd_data,
    output rd_hit
  );
endinterface

// File: rtl/interrupt_ctrl.sv
// Memory-mapped 16-line interrupt controller with reload timer.
// Ports: clk, rst_n (sync), clk_en, irq_in[15:0], bus (slave), interrupts[15:0].
module interrupt_ctrl #(
  parameter logic [17:0] BASE_ADDR = 18'h3FFE0,
  parameter int          TIMER_IRQ = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_en,
  input  logic [15:0]      irq_in,
  interrupt_ctrl_if.slave  bus,
  output logic [15:0]      interrupts
);

  localparam logic [2:0] R_PEND = 3'd0;
  localparam logic [2:0] R_MASK = 3'd1;
  localparam logic [2:0] R_MODE = 3'd2;
  localparam logic [2:0] R_RELD = 3'd3;
  localparam logic [2:0] R_CNT  = 3'd4;
  localparam logic [2:0] R_RAW  = 3'd5;

  logic [15:0] sync1;
  logic [15:0] sync;
  logic [15:0] prev;
  logic [15:0] pending;
  logic [15:0] mask;
  logic [15:0] mode;
  logic [31:0] reload;
  logic [31:0] count;

  logic        wr_hit;
  logic        wr_en;
  logic [2:0]  wr_sel;
  logic [31:0] bmask;
  logic [31:0] wdata;
  logic        wr_pend;
  logic        wr_mask;
  logic        wr_mode;
  logic        wr_reload;
  logic [15:0] mask_new;
  logic [15:0] mode_new;
  logic [31:0] reload_new;

  logic        rd_dec;
  logic [31:0] rmux;

  logic        timer_pulse;
  logic [15:0] tmr_vec;
  logic [15:0] edge_ev;
  logic [15:0] clr;
  logic [15:0] pend_next;

  assign wr_hit = bus.mem_write_addr[17:5] == BASE_ADDR[17:5];
  assign wr_en  = clk_en && wr_hit && (bus.mem_we != 4'b0);
  assign wr_sel = bus.mem_write_addr[4:2];

  always_comb begin
    bmask = '0;
    for (int b = 0; b < 4; b++)
      bmask[8*b +: 8] = {8{bus.mem_we[b]}};
  end

  assign wdata     = bus.mem_write_data & bmask;
  assign wr_pend   = wr_en && (wr_sel == R_PEND);
  assign wr_mask   = wr_en && (wr_sel == R_MASK);
  assign wr_mode   = wr_en && (wr_sel == R_MODE);
  assign wr_reload = wr_en && (wr_sel == R_RELD);

  assign mask_new   = (mask & ~bmask[15:0]) | wdata[15:0];
  assign mode_new   = (mode & ~bmask[15:0]) | wdata[15:0];
  assign reload_new = (reload & ~bmask) | wdata;

  // A same-cycle RELOAD write restarts the timer and suppresses the pulse.
  assign timer_pulse = clk_en && (reload != 32'd0) &&
                       (count <= 32'd1) && !wr_reload;

  always_comb begin
    tmr_vec = '0;
    tmr_vec[TIMER_IRQ] = timer_pulse;
  end

  assign edge_ev = sync & ~prev;
  assign clr     = wr_pend ? wdata[15:0] : 16'h0;

  // Level lines track the synchronized input; edge lines latch with
  // set taking priority over a same-cycle write-1-to-clear.
  assign pend_next = (~mode & (sync | tmr_vec)) |
                     (mode & (edge_ev | tmr_vec | (pending & ~clr)));

  assign rd_dec = bus.rd_addr[17:5] == BASE_ADDR[17:5];

  always_comb begin
    rmux = '0;
    unique case (bus.rd_addr[4:2])
      R_PEND:  rmux = {16'h0, pending};
      R_MASK:  rmux = {16'h0, mask};
      R_MODE:  rmux = {16'h0, mode};
      R_RELD:  rmux = reload;
      R_CNT:   rmux = count;
      R_RAW:   rmux = {16'h0, sync};
      3'd6:    rmux = '0;
      3'd7:    rmux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1       <= '0;
      sync        <= '0;
      prev        <= '0;
      pending     <= '0;
      mask        <= '0;
      mode        <= '0;
      reload      <= '0;
      count       <= '0;
      bus.rd_data <= '0;
      bus.rd_hit  <= 1'b0;
    end else begin
      sync1   <= irq_in;
      sync    <= sync1;
      prev    <= sync;
      pending <= pend_next;
      if (wr_mask)
        mask <= mask_new;
      if (wr_mode)
        mode <= mode_new;
      if (wr_reload) begin
        reload <= reload_new;
        count  <= reload_new;
      end else if (clk_en && (reload != 32'd0)) begin
        count <= (count <= 32'd1) ? reload : count - 32'd1;
      end
      bus.rd_data <= rd_dec ? rmux : 32'h0;
      bus.rd_hit  <= rd_dec;
    end
  end

  assign interrupts = pending & mask;

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Self-checking bench for interrupt_ctrl: directed steps then random traffic.
// A behavioural model tracks the register block cycle by cycle.
module tb_interrupt_ctrl;

  localparam logic [17:0] BASE = 18'h3FFE0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_en = 1'b0;
  logic [15:0] irq_in = 16'h0;
  logic [15:0] interrupts;

  interrupt_ctrl_if bus();

  interrupt_ctrl #(.BASE_ADDR(BASE), .TIMER_IRQ(0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk_en     (clk_en),
    .irq_in     (irq_in),
    .bus        (bus),
    .interrupts (interrupts)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model state: the irq_in history stands in for the synchronizer
  logic [15:0] h1, h2, h3;
  logic [15:0] m_pend, m_mask, m_mode;
  logic [31:0] m_reload, m_count, m_rd;
  logic        m_hit;

  function automatic bit in_block(input logic [17:0] a);
    return (a >= {BASE[17:5], 5'd0}) && (a <= {BASE[17:5], 5'd31});
  endfunction

  function automatic logic [31:0] reg_value(input int idx);
    case (idx)
      0: return {16'h0, m_pend};
      1: return {16'h0, m_mask};
      2: return {16'h0, m_mode};
      3: return m_reload;
      4: return m_count;
      5: return {16'h0, h2};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] apply_bytes(input logic [31:0] old,
                                              input logic [31:0] nw,
                                              input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (we[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic model_step();
    bit          wr;
    int          widx;
    bit          pulse;
    logic [31:0] v;
    logic [15:0] np;
    logic [31:0] nc, nr;
    logic [15:0] nm, nd;
    if (!rst_n) begin
      h1 = 0; h2 = 0; h3 = 0;
      m_pend = 0; m_mask = 0; m_mode = 0;
      m_reload = 0; m_count = 0; m_rd = 0; m_hit = 0;
      return;
    end
    wr = clk_en && in_block(bus.mem_write_addr) && (bus.mem_we != 0);
    widx = wr ? int'(bus.mem_write_addr[4:2]) : -1;
    nm = m_mask; nd = m_mode; nr = m_reload; nc = m_count;
    if (widx == 1) begin
      v = apply_bytes({16'h0, m_mask}, bus.mem_write_data, bus.mem_we);
      nm = v[15:0];
    end
    if (widx == 2) begin
      v = apply_bytes({16'h0, m_mode}, bus.mem_write_data, bus.mem_we);
      nd = v[15:0];
    end
    pulse = 0;
    if (widx == 3) begin
      nr = apply_bytes(m_reload, bus.mem_write_data, bus.mem_we);
      nc = nr;
    end else if (clk_en && m_reload != 0) begin
      if (m_count <= 1) begin
        nc = m_reload;
        pulse = 1;
      end else begin
        nc = m_count - 1;
      end
    end
    v = apply_bytes(32'h0, bus.mem_write_data, bus.mem_we);
    for (int i = 0; i < 16; i++) begin
      bit setb, clrb;
      setb = (h2[i] && !h3[i]) || (pulse && i == 0);
      clrb = (widx == 0) && v[i];
      if (!m_mode[i])
        np[i] = h2[i] || (pulse && i == 0);
      else if (setb)
        np[i] = 1'b1;
      else if (clrb)
        np[i] = 1'b0;
      else
        np[i] = m_pend[i];
    end
    m_rd = in_block(bus.rd_addr) ? reg_value(int'(bus.rd_addr[4:2])) : 0;
    m_hit = in_block(bus.rd_addr);
    m_pend = np; m_mask = nm; m_mode = nd; m_reload = nr; m_count = nc;
    h3 = h2; h2 = h1; h1 = irq_in;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("interrupts", {16'h0, interrupts}, {16'h0, m_pend & m_mask});
    chk("rd_data", bus.rd_data, m_rd);
    chk("rd_hit", {31'h0, bus.rd_hit}, {31'h0, m_hit});
  endtask

  task automatic wr(input logic [4:0] off, input logic [31:0] d,
                    input logic [3:0] we);
    bus.mem_write_addr = BASE + 18'(off);
    bus.mem_write_data = d;
    bus.mem_we = we;
    tick();
    bus.mem_we = 4'h0;
  endtask

  int          rises[$];
  logic [31:0] cnt_seq[$];
  logic [31:0] last;
  bit          prev_int;
  bit          clr_req;

  initial begin
    bus.mem_we = 0;
    bus.mem_write_addr = 0;
    bus.mem_write_data = 0;
    bus.rd_addr = BASE;

    // reset with all lines high
    rst_n = 0; irq_in = 16'hFFFF; clk_en = 1;
    tick(); tick();
    chk("reset_int", {16'h0, interrupts}, 32'h0);
    chk("reset_rd", bus.rd_data, 32'h0);
    rst_n = 1;
    repeat (4) tick();
    chk("lvl_pend_all", bus.rd_data, 32'h0000FFFF);
    chk("lvl_masked", {16'h0, interrupts}, 32'h0);

    // edge detect on line 1
    irq_in = 0;
    repeat (3) tick();
    wr(5'h08, 32'h2, 4'hF);
    wr(5'h04, 32'h2, 4'hF);
    irq_in = 16'h0002; tick();
    irq_in = 0; tick();
    chk("edge_early", {16'h0, interrupts}, 32'h0);
    tick();
    chk("edge_3clk", {16'h0, interrupts}, 32'h2);
    wr(5'h00, 32'h2, 4'hF);
    chk("edge_w1c", {16'h0, interrupts}, 32'h0);

    // set beats same-cycle clear
    irq_in = 16'h0002; tick();
    irq_in = 0; tick();
    wr(5'h00, 32'h2, 4'hF);
    chk("set_beats_clr", {16'h0, interrupts}, 32'h2);
    wr(5'h00, 32'h2, 4'hF);

    // level mode on line 5
    wr(5'h08, 32'h0, 4'hF);
    wr(5'h04, 32'h20, 4'hF);
    irq_in = 16'h0020;
    repeat (3) tick();
    chk("lvl_set", {16'h0, interrupts}, 32'h20);
    wr(5'h00, 32'h20, 4'hF);
    chk("lvl_w1c_noeff", {16'h0, interrupts}, 32'h20);
    irq_in = 0;
    tick(); tick();
    chk("lvl_hold2", {16'h0, interrupts}, 32'h20);
    tick();
    chk("lvl_drop3", {16'h0, interrupts}, 32'h0);

    // timer on line 0, clk_en every 4th clock
    wr(5'h08, 32'h1, 4'hF);
    wr(5'h04, 32'h1, 4'hF);
    wr(5'h00, 32'hFFFF, 4'hF);
    bus.rd_addr = BASE + 18'h10;
    clk_en = 1;
    wr(5'h0C, 32'd3, 4'hF);
    last = 32'hFFFF_FFFF;
    prev_int = 0; clr_req = 0;
    for (int c = 1; c <= 50; c++) begin
      clk_en = (c % 4 == 0);
      if (clk_en && clr_req) begin
        bus.mem_write_addr = BASE;
        bus.mem_write_data = 32'h1;
        bus.mem_we = 4'hF;
        clr_req = 0;
      end
      tick();
      bus.mem_we = 0;
      if (interrupts[0] && !prev_int) begin
        rises.push_back(c);
        clr_req = 1;
      end
      prev_int = interrupts[0];
      if (bus.rd_data !== last) begin
        cnt_seq.push_back(bus.rd_data);
        last = bus.rd_data;
      end
    end
    chk("tmr_rises", rises.size(), 4);
    for (int i = 1; i < rises.size(); i++)
      chk("tmr_period", rises[i] - rises[i-1], 12);
    if (cnt_seq.size() >= 4) begin
      chk("cnt_seq0", cnt_seq[0], 3);
      chk("cnt_seq1", cnt_seq[1], 2);
      chk("cnt_seq2", cnt_seq[2], 1);
      chk("cnt_seq3", cnt_seq[3], 3);
    end else begin
      chk("cnt_seq_len", cnt_seq.size(), 4);
    end
    clk_en = 1;
    wr(5'h00, 32'h1, 4'hF);
    wr(5'h0C, 32'h0, 4'hF);
    repeat (10) tick();
    chk("tmr_stopped", bus.rd_data, 32'h0);
    chk("tmr_noirq", {16'h0, interrupts}, 32'h0);

    // byte enables and decode
    wr(5'h04, 32'h0, 4'hF);
    bus.rd_addr = BASE + 18'h4;
    wr(5'h04, 32'hAABBCCDD, 4'b0001);
    tick();
    chk("mask_byte0", bus.rd_data, 32'h000000DD);
    clk_en = 0;
    wr(5'h04, 32'hFFFFFFFF, 4'hF);
    clk_en = 1;
    tick();
    chk("mask_noclken", bus.rd_data, 32'h000000DD);
    wr(5'h04, 32'h00001234, 4'hF);
    chk("rd_prewrite", bus.rd_data, 32'h000000DD);
    tick();
    chk("rd_postwrite", bus.rd_data, 32'h00001234);
    bus.rd_addr = BASE + 18'h18;
    tick();
    chk("rsvd_data", bus.rd_data, 32'h0);
    chk("rsvd_hit", {31'h0, bus.rd_hit}, 32'h1);
    bus.rd_addr = BASE - 18'h4;
    tick();
    chk("miss_hit", {31'h0, bus.rd_hit}, 32'h0);

    // reset mid-count abandons the timer
    wr(5'h0C, 32'd100, 4'hF);
    rst_n = 0; tick();
    rst_n = 1;
    bus.rd_addr = BASE + 18'h10;
    tick();
    chk("rst_count", bus.rd_data, 32'h0);

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [4:0] off;
      rst_n = ($urandom_range(0, 199) != 0);
      clk_en = $urandom_range(0, 1);
      if ($urandom_range(0, 3) == 0)
        irq_in = irq_in ^ 16'($urandom);
      if ($urandom_range(0, 9) < 3) begin
        off = 5'($urandom);
        bus.mem_write_addr = ($urandom_range(0, 7) == 0) ?
                             18'($urandom) : BASE + 18'(off);
        bus.mem_write_data = (off[4:2] == 3'd3) ?
                             32'($urandom_range(0, 6)) : $urandom;
        bus.mem_we = 4'($urandom);
      end else begin
        bus.mem_we = 0;
      end
      bus.rd_addr = ($urandom_range(0, 7) == 0) ?
                    18'($urandom) : BASE + 18'($urandom_range(0, 31));
      tick();
    end
    bus.mem_we = 0;
    rst_n = 1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
